// File: rtl/lcd_hd44780_ctrl_if.sv
// Byte handshake between the display logic (master) and the HD44780 controller (slave).
interface lcd_hd44780_ctrl_if;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only bus controller: power-on init sequence, then timed
// E-strobe write cycles for command/data bytes taken over a valid/ready handshake.
module lcd_hd44780_ctrl #(
  parameter int unsigned POWERUP_CYCLES = 20,
  parameter int unsigned INIT_LONG_WAIT = 5,
  parameter int unsigned SHORT_WAIT     = 1,
  parameter int unsigned LONG_WAIT      = 2
) (
  input  logic                      clk_1ms,
  input  logic                      reset,
  lcd_hd44780_ctrl_if.slave         bus,
  output logic                      init_done,
  output logic                      E,
  output logic                      RW,
  output logic                      RS,
  output logic [7:0]                DB
);

  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > INIT_LONG_WAIT) ? POWERUP_CYCLES : INIT_LONG_WAIT;
  localparam int unsigned MAX_CNT = (MAX_AB > LONG_WAIT) ? MAX_AB : LONG_WAIT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned N_INIT  = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [3:0] {
    PWRUP, INIT_SETUP, INIT_EHI, INIT_ELO, INIT_WAIT,
    IDLE, WR_SETUP, WR_EHI, WR_ELO, WR_WAIT
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               e_q, e_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               rs_q, rs_d;
  logic [7:0]         db_q, db_d;

  function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] i);
    case (i)
      3'd0, 3'd1, 3'd2, 3'd3: init_byte = 8'h38;
      3'd4:                   init_byte = 8'h08;
      3'd5:                   init_byte = 8'h01;
      3'd6:                   init_byte = 8'h06;
      default:                init_byte = 8'h0C;
    endcase
  endfunction

  // Wait-state count minus one, so the WAIT state ends when the counter reaches 0.
  function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic [7:0] data,
                                                 input logic first);
    int unsigned w;
    if (first)                                      w = INIT_LONG_WAIT;
    else if (!rs && (data inside {8'h01, 8'h02, 8'h03})) w = LONG_WAIT;
    else                                            w = SHORT_WAIT;
    if (w == 0) w = 1;
    return CNT_W'(w - 1);
  endfunction

  // State and output registers
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state   <= PWRUP;
      cnt     <= '0;
      idx     <= '0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      idx     <= idx_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

  // Next-state, wait counter and init index
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    case (state)
      PWRUP: begin
        if (cnt == CNT_W'(POWERUP_CYCLES)) begin
          state_d = INIT_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      INIT_SETUP: state_d = INIT_EHI;
      INIT_EHI:   state_d = INIT_ELO;
      INIT_ELO: begin
        state_d = INIT_WAIT;
        cnt_d   = wait_load(rs_q, db_q, idx == '0);
      end
      INIT_WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (idx == IDX_W'(N_INIT - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = INIT_SETUP;
          idx_d   = idx + IDX_W'(1);
        end
      end
      IDLE: if (ready_q && bus.in_valid) state_d = WR_SETUP;
      WR_SETUP: state_d = WR_EHI;
      WR_EHI:   state_d = WR_ELO;
      WR_ELO: begin
        state_d = WR_WAIT;
        cnt_d   = wait_load(rs_q, db_q, 1'b0);
      end
      WR_WAIT: begin
        if (cnt != '0) cnt_d = cnt - CNT_W'(1);
        else           state_d = IDLE;
      end
      default: state_d = PWRUP;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to
  always_comb begin
    e_d     = (state_d == INIT_EHI) || (state_d == WR_EHI);
    ready_d = (state_d == IDLE);
    done_d  = done_q || (state_d == IDLE);
    rs_d    = rs_q;
    db_d    = db_q;
    if (state_d == INIT_SETUP) begin
      rs_d = 1'b0;
      db_d = init_byte(idx_d);
    end else if (state_d == WR_SETUP) begin
      rs_d = bus.in_rs;
      db_d = bus.in_data;
    end
  end

  assign bus.in_ready = ready_q;
  assign init_done    = done_q;
  assign E            = e_q;
  assign RW           = 1'b0;
  assign RS           = rs_q;
  assign DB           = db_q;

endmodule
